// File: rtl/ram_dp_if.sv
// Bus bundle for ram_dp: port A read/byte-write access and port B read-only access.
// The master side issues requests; the slave side (the RAM) returns data and valid pulses.
interface ram_dp_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int BWIDTH = 8
);
  localparam int NB = DWIDTH / BWIDTH;

  logic              a_en;
  logic [NB-1:0]     a_we;
  logic [AWIDTH-1:0] a_addr;
  logic [DWIDTH-1:0] a_d;
  logic [DWIDTH-1:0] a_q;
  logic              a_qvalid;

  logic              b_en;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] b_q;
  logic              b_qvalid;

  modport master (
    output a_en, a_we, a_addr, a_d, b_en, b_addr,
    input  a_q, a_qvalid, b_q, b_qvalid
  );

  modport slave (
    input  a_en, a_we, a_addr, a_d, b_en, b_addr,
    output a_q, a_qvalid, b_q, b_qvalid
  );
endinterface

// File: rtl/ram_dp.sv
// Dual-port synchronous RAM: port A read + byte-enabled write, port B read-only.
// A clear engine zeroes the array after reset; ready marks the end of clearing.
module ram_dp #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int WORDS    = 4096,
  parameter int BWIDTH   = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic     clk,
  input  logic     n_reset,
  output logic     ready,
  ram_dp_if.slave  bus
);
  localparam int NB  = DWIDTH / BWIDTH;
  localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW1 = AWIDTH + 1;
  localparam logic [AW1-1:0] WORDS_L = AW1'(WORDS);
  localparam logic [IW-1:0]  LAST    = IW'(WORDS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [IW-1:0]     cnt;
  logic [DWIDTH-1:0] mem [WORDS];

  logic              run, clearing;
  logic              acc_a, acc_b;
  logic              a_inr, b_inr, a_wr, b_hit;
  logic [IW-1:0]     a_idx, b_idx;
  logic [DWIDTH-1:0] a_old, b_old, a_merged, a_rdata, b_rdata;

  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic [NB-1:0]     wr_lane;
  logic [DWIDTH-1:0] wr_data;

  logic              a_rv, b_rv;
  logic [DWIDTH-1:0] a_r, b_r;

  assign run      = (state == RUN);
  assign clearing = (state == CLEAR);
  assign acc_a    = run && bus.a_en;
  assign acc_b    = run && bus.b_en;

  assign a_idx = bus.a_addr[IW-1:0];
  assign b_idx = bus.b_addr[IW-1:0];
  assign a_inr = {1'b0, bus.a_addr} < WORDS_L;
  assign b_inr = {1'b0, bus.b_addr} < WORDS_L;

  assign a_old = a_inr ? mem[a_idx] : '0;
  assign b_old = b_inr ? mem[b_idx] : '0;

  // NOTE: a_merged gets a full default before the lane loop so no path leaves it unassigned (no latch).
  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (bus.a_we[i]) a_merged[i*BWIDTH +: BWIDTH] = bus.a_d[i*BWIDTH +: BWIDTH];
    end
  end

  assign a_wr  = acc_a && a_inr && (|bus.a_we);
  assign b_hit = (RDW_MODE != 0) && a_wr && (bus.a_addr == bus.b_addr);

  // New-data mode forwards the merged word; old-data mode uses the pre-edge array contents.
  assign a_rdata = !a_inr ? '0 : ((RDW_MODE != 0) ? a_merged : a_old);
  assign b_rdata = !b_inr ? '0 : (b_hit ? a_merged : b_old);

  assign wr_en   = clearing || a_wr;
  assign wr_idx  = clearing ? cnt : a_idx;
  assign wr_lane = clearing ? '1 : bus.a_we;
  assign wr_data = clearing ? '0 : bus.a_d;

  // NOTE: the array has no reset branch; the clear engine zeroes it, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_lane[i]) mem[wr_idx][i*BWIDTH +: BWIDTH] <= wr_data[i*BWIDTH +: BWIDTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_r  <= '0;
      a_rv <= 1'b0;
      b_r  <= '0;
      b_rv <= 1'b0;
    end else begin
      a_rv <= acc_a;
      b_rv <= acc_b;
      if (acc_a) a_r <= a_rdata;
      if (acc_b) b_r <= b_rdata;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DWIDTH-1:0] a_q2, b_q2;
      logic              a_v2, b_v2;

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          a_q2 <= '0;
          a_v2 <= 1'b0;
          b_q2 <= '0;
          b_v2 <= 1'b0;
        end else begin
          a_v2 <= a_rv;
          b_v2 <= b_rv;
          if (a_rv) a_q2 <= a_r;
          if (b_rv) b_q2 <= b_r;
        end
      end

      assign bus.a_q      = a_q2;
      assign bus.a_qvalid = a_v2;
      assign bus.b_q      = b_q2;
      assign bus.b_qvalid = b_v2;
    end else begin : g_direct
      assign bus.a_q      = a_r;
      assign bus.a_qvalid = a_rv;
      assign bus.b_q      = b_r;
      assign bus.b_qvalid = b_rv;
    end
  endgenerate
endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: three configurations share one stimulus stream; a behavioural
// memory model pushes expected read results into per-port queues that are popped as data returns.
module tb_ram_dp;
  localparam int ND = 3;
  localparam int W_T   [ND] = '{16, 3000, 3000};
  localparam int RDW_T [ND] = '{0, 0, 1};
  localparam int OUT_T [ND] = '{0, 0, 1};

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        a_en, b_en;
  logic [1:0]  a_we;
  logic [11:0] a_addr, b_addr;
  logic [15:0] a_d;

  logic        rdy [ND];
  logic        aqv [ND], bqv [ND];
  logic [15:0] aq  [ND], bq  [ND];

  exp_t        qa [ND][$];
  exp_t        qb [ND][$];
  logic [15:0] mdl [ND][4096];
  logic [15:0] hold_a [ND], hold_b [ND];
  int          clr_cnt [ND];
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  ram_dp_if #(.DWIDTH(16), .AWIDTH(12), .BWIDTH(8)) bus0 ();
  ram_dp_if #(.DWIDTH(16), .AWIDTH(12), .BWIDTH(8)) bus1 ();
  ram_dp_if #(.DWIDTH(16), .AWIDTH(12), .BWIDTH(8)) bus2 ();

  assign bus0.a_en = a_en;  assign bus0.a_we = a_we;  assign bus0.a_addr = a_addr;
  assign bus0.a_d  = a_d;   assign bus0.b_en = b_en;  assign bus0.b_addr = b_addr;
  assign bus1.a_en = a_en;  assign bus1.a_we = a_we;  assign bus1.a_addr = a_addr;
  assign bus1.a_d  = a_d;   assign bus1.b_en = b_en;  assign bus1.b_addr = b_addr;
  assign bus2.a_en = a_en;  assign bus2.a_we = a_we;  assign bus2.a_addr = a_addr;
  assign bus2.a_d  = a_d;   assign bus2.b_en = b_en;  assign bus2.b_addr = b_addr;

  assign aq[0] = bus0.a_q;  assign aqv[0] = bus0.a_qvalid;
  assign bq[0] = bus0.b_q;  assign bqv[0] = bus0.b_qvalid;
  assign aq[1] = bus1.a_q;  assign aqv[1] = bus1.a_qvalid;
  assign bq[1] = bus1.b_q;  assign bqv[1] = bus1.b_qvalid;
  assign aq[2] = bus2.a_q;  assign aqv[2] = bus2.a_qvalid;
  assign bq[2] = bus2.b_q;  assign bqv[2] = bus2.b_qvalid;

  ram_dp #(.DWIDTH(16), .AWIDTH(12), .WORDS(16), .BWIDTH(8), .RDW_MODE(0), .OUT_REG(0))
    dut0 (.clk(clk), .n_reset(n_reset), .ready(rdy[0]), .bus(bus0.slave));
  ram_dp #(.DWIDTH(16), .AWIDTH(12), .WORDS(3000), .BWIDTH(8), .RDW_MODE(0), .OUT_REG(0))
    dut1 (.clk(clk), .n_reset(n_reset), .ready(rdy[1]), .bus(bus1.slave));
  ram_dp #(.DWIDTH(16), .AWIDTH(12), .WORDS(3000), .BWIDTH(8), .RDW_MODE(1), .OUT_REG(1))
    dut2 (.clk(clk), .n_reset(n_reset), .ready(rdy[2]), .bus(bus2.slave));

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d edge %0d: got %h expected %h", tag, g, edge_cnt, obs, exp);
  endtask

  task automatic drive(input logic ae, input logic [1:0] we, input logic [11:0] aa,
                       input logic [15:0] ad, input logic be, input logic [11:0] ba);
    a_en = ae; a_we = we; a_addr = aa; a_d = ad; b_en = be; b_addr = ba;
  endtask

  task automatic sample(input int g);
    bit ev;
    check("ready", g, 32'(rdy[g]), 32'(clr_cnt[g] >= W_T[g]));
    ev = (qa[g].size() > 0) && (qa[g][0].due == edge_cnt);
    check("a_qvalid", g, 32'(aqv[g]), 32'(ev));
    if (ev) begin
      hold_a[g] = qa[g][0].d;
      void'(qa[g].pop_front());
    end
    check("a_q", g, 32'(aq[g]), 32'(hold_a[g]));
    ev = (qb[g].size() > 0) && (qb[g][0].due == edge_cnt);
    check("b_qvalid", g, 32'(bqv[g]), 32'(ev));
    if (ev) begin
      hold_b[g] = qb[g][0].d;
      void'(qb[g].pop_front());
    end
    check("b_q", g, 32'(bq[g]), 32'(hold_b[g]));
  endtask

  // One clock: predict each configuration's results for the current inputs, then compare after the edge.
  task automatic tick();
    logic [15:0] old_a, old_b, mrg, rd;
    bit          a_in, b_in, wr;
    exp_t        e;
    for (int g = 0; g < ND; g++) begin
      if (clr_cnt[g] >= W_T[g]) begin
        a_in  = int'(a_addr) < W_T[g];
        b_in  = int'(b_addr) < W_T[g];
        old_a = a_in ? mdl[g][a_addr] : 16'h0000;
        old_b = b_in ? mdl[g][b_addr] : 16'h0000;
        mrg   = old_a;
        if (a_we[0]) mrg[7:0]  = a_d[7:0];
        if (a_we[1]) mrg[15:8] = a_d[15:8];
        wr = a_en && a_in && (a_we != 2'b00);
        if (a_en) begin
          rd = !a_in ? 16'h0000 : ((RDW_T[g] == 1) ? mrg : old_a);
          e.due = edge_cnt + 1 + OUT_T[g];
          e.d   = rd;
          qa[g].push_back(e);
        end
        if (b_en) begin
          rd = !b_in ? 16'h0000 : ((wr && a_addr == b_addr && RDW_T[g] == 1) ? mrg : old_b);
          e.due = edge_cnt + 1 + OUT_T[g];
          e.d   = rd;
          qb[g].push_back(e);
        end
        if (wr) mdl[g][a_addr] = mrg;
      end
    end
    @(posedge clk);
    edge_cnt++;
    for (int g = 0; g < ND; g++) begin
      if (n_reset && clr_cnt[g] < W_T[g]) clr_cnt[g]++;
    end
    @(negedge clk);
    for (int g = 0; g < ND; g++) sample(g);
  endtask

  task automatic op(input logic ae, input logic [1:0] we, input logic [11:0] aa,
                    input logic [15:0] ad, input logic be, input logic [11:0] ba);
    drive(ae, we, aa, ad, be, ba);
    tick();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'b00, 12'h000, 16'h0000, 1'b0, 12'h000);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 12'h000, 16'h0000, 1'b0, 12'h000);
    n_reset = 1'b0;
    #1;
    for (int g = 0; g < ND; g++) begin
      clr_cnt[g] = 0;
      qa[g].delete();
      qb[g].delete();
      hold_a[g] = 16'h0000;
      hold_b[g] = 16'h0000;
      for (int i = 0; i < 4096; i++) mdl[g][i] = 16'h0000;
      check("rst_ready", g, 32'(rdy[g]), 32'd0);
      check("rst_a_qvalid", g, 32'(aqv[g]), 32'd0);
      check("rst_b_qvalid", g, 32'(bqv[g]), 32'd0);
      check("rst_a_q", g, 32'(aq[g]), 32'd0);
      check("rst_b_q", g, 32'(bq[g]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    edge_cnt += 2;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset = 1'b1;
    drive(1'b0, 2'b00, 12'h000, 16'h0000, 1'b0, 12'h000);
    @(negedge clk);

    // Reset, run five clear cycles, then reset again mid-clear.
    do_reset();
    idle(5);
    do_reset();

    // Requests during clearing must be ignored; addr 0 is already cleared when they arrive.
    for (int i = 0; i < 3002; i++) begin
      if (i >= 10 && i < 13) drive(1'b1, 2'b11, 12'h000, 16'hBEEF, 1'b1, 12'h000);
      else                   drive(1'b0, 2'b00, 12'h000, 16'h0000, 1'b0, 12'h000);
      tick();
    end

    // Cleared contents on both ports.
    for (int i = 0; i < 16; i++) op(1'b1, 2'b00, 12'(15 - i), 16'h0000, 1'b1, 12'(i));
    idle(3);

    // Byte-lane writes.
    op(1'b1, 2'b11, 12'h001, 16'h1234, 1'b0, 12'h000);
    op(1'b1, 2'b10, 12'h001, 16'hAB00, 1'b0, 12'h000);
    op(1'b1, 2'b00, 12'h001, 16'h0000, 1'b1, 12'h001);
    idle(3);

    // Read-during-write on port B, then on port A itself.
    op(1'b1, 2'b11, 12'h010, 16'h5555, 1'b0, 12'h000);
    op(1'b1, 2'b11, 12'h010, 16'hAAAA, 1'b1, 12'h010);
    op(1'b0, 2'b00, 12'h000, 16'h0000, 1'b1, 12'h010);
    op(1'b1, 2'b01, 12'h010, 16'h00CC, 1'b0, 12'h000);
    op(1'b1, 2'b00, 12'h010, 16'h0000, 1'b1, 12'h010);
    idle(3);

    // Out-of-range and last-word boundaries.
    op(1'b1, 2'b11, 12'hFFF, 16'hFFFF, 1'b0, 12'h000);
    op(1'b1, 2'b00, 12'hFFF, 16'h0000, 1'b1, 12'hFFF);
    op(1'b1, 2'b00, 12'h000, 16'h0000, 1'b1, 12'h000);
    op(1'b1, 2'b11, 12'h00F, 16'h0F0F, 1'b0, 12'h000);
    op(1'b1, 2'b11, 12'hBB7, 16'hBB7B, 1'b0, 12'h000);
    op(1'b1, 2'b11, 12'hBB8, 16'h1111, 1'b0, 12'h000);
    op(1'b1, 2'b00, 12'h00F, 16'h0000, 1'b1, 12'hBB7);
    op(1'b1, 2'b00, 12'hBB8, 16'h0000, 1'b1, 12'h010);
    idle(3);

    // Back-to-back reads for pipeline ordering and latency.
    op(1'b1, 2'b11, 12'h002, 16'h2222, 1'b0, 12'h000);
    op(1'b1, 2'b11, 12'h003, 16'h3333, 1'b0, 12'h000);
    op(1'b1, 2'b00, 12'h001, 16'h0000, 1'b1, 12'h003);
    op(1'b1, 2'b00, 12'h002, 16'h0000, 1'b1, 12'h002);
    op(1'b1, 2'b00, 12'h003, 16'h0000, 1'b1, 12'h001);
    idle(4);

    // Reset during run with a read in flight; the array must come back cleared.
    op(1'b1, 2'b00, 12'h001, 16'h0000, 1'b1, 12'h002);
    do_reset();
    idle(3002);
    op(1'b1, 2'b00, 12'h001, 16'h0000, 1'b1, 12'h002);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
